// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Brief    : Conditions one raw, bouncy push-button pin into a clean,
//            synchronous "pressed" level and derives single-cycle press,
//            release and long-press events plus a wrapping press counter.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
  parameter int DEBOUNCE_CYCLES   = 270000,    // cycles a new level must hold
  parameter int LONG_PRESS_CYCLES = 27000000,  // cycles after press for long_pulse
  parameter bit ACTIVE_LOW        = 1'b1       // 1: pin reads low when pressed
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  // --------------------------------------------------------------------------
  // Counter widths and terminal values. Both counters compare against N-1
  // because the edge that reaches the terminal value is itself the Nth edge.
  // --------------------------------------------------------------------------
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0]   c_db_last   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   c_db_one    = DB_W'(1);
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] c_hold_one  = HOLD_W'(1);
  localparam logic [7:0]        c_cnt_one   = 8'd1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // Two-flop synchroniser; the first stage already holds the normalised
  // value (1 = pressed) so every downstream comparison is polarity-free.
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;

  // Debounce: accepted level and the run-length of disagreement with it.
  logic              btn_level_q, btn_level_d;
  logic [DB_W-1:0]   db_cnt_q,    db_cnt_d;

  // Event pulses, all registered so no path from btn_in reaches an output.
  logic              press_q,     press_d;
  logic              release_q,   release_d;
  logic              long_q,      long_d;

  // Press counter (wraps naturally at 8 bits).
  logic [7:0]        count_q,     count_d;

  // Long-press tracking: hold time since the press event, and a flag that
  // freezes the counter once the long event has been emitted for this press.
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic              fired_q,     fired_d;

  // Synchroniser next-state: normalise polarity at the pin, then shift.
  always_comb begin
    sync1_d = ACTIVE_LOW ? ~btn_in : btn_in;
    sync2_d = sync1_q;
  end

  // Debounce next-state: accept sync2 only after it disagrees with the
  // current level for DEBOUNCE_CYCLES consecutive edges; any agreement
  // restarts the run from zero so short glitches are forgotten entirely.
  always_comb begin
    btn_level_d = btn_level_q;
    db_cnt_d    = db_cnt_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    if (sync2_q == btn_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == c_db_last) begin
      btn_level_d = sync2_q;
      db_cnt_d    = '0;
      // The new level decides which event fires; only one can be true.
      press_d     = sync2_q;
      release_d   = ~sync2_q;
    end else begin
      db_cnt_d = db_cnt_q + c_db_one;
    end
  end

  // Press counter next-state: advances together with the press event so the
  // count already includes a press in the cycle its pulse is visible.
  always_comb begin
    count_d = count_q;
    if (press_d) begin
      count_d = count_q + c_cnt_one;
    end
  end

  // Long-press next-state: count edges while the accepted level is pressed,
  // fire once at the threshold, then stop until the next press restarts it.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    fired_d    = fired_q;
    long_d     = 1'b0;
    if (press_d) begin
      // Fresh press: start timing from the press event itself.
      hold_cnt_d = '0;
      fired_d    = 1'b0;
    end else if (!btn_level_q) begin
      // Released: keep the tracker idle so an early release never fires.
      hold_cnt_d = '0;
      fired_d    = 1'b0;
    end else if (!fired_q) begin
      if (hold_cnt_q == c_hold_last) begin
        long_d  = 1'b1;
        fired_d = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + c_hold_one;
      end
    end
  end

  // State registers: a reset edge returns everything to "released, idle"
  // and suppresses any pulse that would otherwise have fired on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      btn_level_q <= 1'b0;
      db_cnt_q    <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      count_q     <= 8'd0;
      hold_cnt_q  <= '0;
      fired_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      btn_level_q <= btn_level_d;
      db_cnt_q    <= db_cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      count_q     <= count_d;
      hold_cnt_q  <= hold_cnt_d;
      fired_q     <= fired_d;
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    btn_level     = btn_level_q;
    press_pulse   = press_q;
    release_pulse = release_q;
    long_pulse    = long_q;
    press_count   = count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debounce
// Brief    : Directed, self-checking bench for button_debounce with
//            DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

  logic       clk;
  logic       rst;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  int n_assert;
  int n_fail;

  button_debounce #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20),
    .ACTIVE_LOW       (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check every output against expected values in one go.
  task automatic chk_all(input string tag, input logic lvl, input logic prs,
                         input logic rel, input logic lng, input logic [7:0] cnt);
    chk({tag, ".level"},   {31'd0, btn_level},     {31'd0, lvl});
    chk({tag, ".press"},   {31'd0, press_pulse},   {31'd0, prs});
    chk({tag, ".release"}, {31'd0, release_pulse}, {31'd0, rel});
    chk({tag, ".long"},    {31'd0, long_pulse},    {31'd0, lng});
    chk({tag, ".count"},   {24'd0, press_count},   {24'd0, cnt});
  endtask

  logic [7:0] exp_cnt;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    btn_in   = 1'b1;

    // 1: reset with button released, then idle 50 cycles
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("s1_reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      chk_all("s1_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    end

    // 2: clean press, then clean release (events after edge 5)
    btn_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_all("s2_press", (k >= 5), (k == 5), 1'b0, 1'b0, (k >= 5) ? 8'd1 : 8'd0);
    end
    btn_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_all("s2_release", (k < 5), 1'b0, (k == 5), 1'b0, 8'd1);
    end

    // 3: bounce pattern 0,1,0,0,1,0 then hold released
    begin
      logic [5:0] pat;
      pat = 6'b010010;  // bit 5 first: 0,1,0,0,1,0
      for (int k = 0; k < 6; k++) begin
        btn_in = pat[5-k];
        tick();
        chk_all("s3_bounce", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
      end
    end
    btn_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_all("s3_settle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    end

    // 4a: long hold -> single long_pulse 20 edges after press event (k=25)
    btn_in = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      chk_all("s4_hold", (k >= 5), (k == 5), 1'b0, (k == 25), (k >= 5) ? 8'd2 : 8'd1);
    end
    btn_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_all("s4_rel1", (k < 5), 1'b0, (k == 5), 1'b0, 8'd2);
    end

    // 4b: short hold (release before threshold) -> no long_pulse
    btn_in = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk_all("s4_short", (k >= 5), (k == 5), 1'b0, 1'b0, (k >= 5) ? 8'd3 : 8'd2);
    end
    btn_in = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk_all("s4_rel2", (k < 5), 1'b0, (k == 5), 1'b0, 8'd3);
    end

    // 5: reset, then 257 clean presses; count wraps 255 -> 0 and ends at 1
    rst = 1'b1;
    tick();
    chk_all("s5_reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    exp_cnt = 8'd0;
    for (int p = 0; p < 257; p++) begin
      btn_in = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      exp_cnt = exp_cnt + 8'd1;
      chk("s5_press_pulse", {31'd0, press_pulse}, 32'd1);
      chk("s5_count", {24'd0, press_count}, {24'd0, exp_cnt});
      btn_in = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      chk("s5_release_pulse", {31'd0, release_pulse}, 32'd1);
      if (p == 255) chk("s5_wrap", {24'd0, press_count}, 32'd0);
    end
    chk("s5_final", {24'd0, press_count}, 32'd1);

    // 6: reset two cycles into a press; re-accepted 6 edges after deassert
    tick();
    btn_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("s6_pre", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    end
    rst = 1'b1;
    tick();
    chk_all("s6_rst_edge", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_all("s6_after", (k >= 5), (k == 5), 1'b0, 1'b0, (k >= 5) ? 8'd1 : 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
